// File: rtl/sync_add.sv
// sync_add: single-digit synchronous up-counter driven by a push button.
// The button is synchronised, debounced and edge-detected. Each accepted
// press advances a 4-bit count that wraps at MAX_COUNT. The count drives an
// active-low 7-segment glyph and emits a one-cycle carry pulse on wrap.
module sync_add #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int MAX_COUNT       = 9
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn,
   input  logic       en,
   output logic [3:0] digit,
   output logic [6:0] leds,
   output logic       carry
);

   localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [3:0]      MAX_D   = 4'(MAX_COUNT);

   logic            btn_p0;
   logic            btn_s;
   logic            btn_clean;
   logic            btn_clean_d;
   logic [DB_W-1:0] db_cnt;
   logic            inc;
   logic [3:0]      digit_nxt;
   logic            carry_nxt;

   // Active-low glyph for one hex digit, bit order {g,f,e,d,c,b,a}.
   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] g;
      case (d)
         4'h0:    g = 7'b1000000;
         4'h1:    g = 7'b1111001;
         4'h2:    g = 7'b0100100;
         4'h3:    g = 7'b0110000;
         4'h4:    g = 7'b0011001;
         4'h5:    g = 7'b0010010;
         4'h6:    g = 7'b0000010;
         4'h7:    g = 7'b1111000;
         4'h8:    g = 7'b0000000;
         4'h9:    g = 7'b0010000;
         4'hA:    g = 7'b0001000;
         4'hB:    g = 7'b0000011;
         4'hC:    g = 7'b1000110;
         4'hD:    g = 7'b0100001;
         4'hE:    g = 7'b0000110;
         default: g = 7'b0001110;
      endcase
      return g;
   endfunction

   // Two-flop synchroniser bringing the raw button into the clk domain.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         btn_p0 <= 1'b0;
         btn_s  <= 1'b0;
      end else begin
         btn_p0 <= btn;
         btn_s  <= btn_p0;
      end
   end

   // Debounce: accept a new level only after it has held for DEBOUNCE_CYCLES edges.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         db_cnt      <= '0;
         btn_clean   <= 1'b0;
         btn_clean_d <= 1'b0;
      end else begin
         btn_clean_d <= btn_clean;
         if (btn_s == btn_clean) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_LAST) begin
            btn_clean <= btn_s;
            db_cnt    <= '0;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end
   end

   // Rising edge of the debounced level, gated by enable, requests one step.
   always_comb begin
      inc = btn_clean & ~btn_clean_d & en;
   end

   // Next count: wrap at MAX_COUNT with carry; an out-of-range count wraps silently.
   always_comb begin
      digit_nxt = digit;
      carry_nxt = 1'b0;
      if (inc) begin
         if (digit == MAX_D) begin
            digit_nxt = 4'd0;
            carry_nxt = 1'b1;
         end else if (digit > MAX_D) begin
            digit_nxt = 4'd0;
         end else begin
            digit_nxt = digit + 4'd1;
         end
      end
   end

   // Count, carry and glyph update together so leds always match digit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         digit <= 4'd0;
         carry <= 1'b0;
         leds  <= 7'b1000000;
      end else begin
         digit <= digit_nxt;
         carry <= carry_nxt;
         leds  <= seg7(digit_nxt);
      end
   end

endmodule

// File: tb/tb_sync_add.sv
// tb_sync_add: directed and random button stimulus for sync_add, compared
// every cycle against a windowed reference model of the counter.
module tb_sync_add;

   localparam int DB   = 4;
   localparam int MAXC = 9;

   logic       clk   = 1'b0;
   logic       reset = 1'b0;
   logic       btn   = 1'b0;
   logic       en    = 1'b0;
   logic [3:0] digit;
   logic [6:0] leds;
   logic       carry;

   int n_assert = 0;
   int n_fail   = 0;

   logic [3:0] m_digit;
   logic       m_carry;
   logic       m_clean;
   logic       m_clean_d;
   logic       hist[$];
   logic [6:0] glyph [0:15];
   int         carry_seen;

   sync_add #(.DEBOUNCE_CYCLES(DB), .MAX_COUNT(MAXC)) dut (
      .clk   (clk),
      .reset (reset),
      .btn   (btn),
      .en    (en),
      .digit (digit),
      .leds  (leds),
      .carry (carry)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      hist.delete();
      repeat (DB + 2) hist.push_back(1'b0);
      m_digit   = 4'd0;
      m_carry   = 1'b0;
      m_clean   = 1'b0;
      m_clean_d = 1'b0;
   endtask

   // One clock edge of the reference: a level is accepted once the DB most
   // recent synchronised samples (two edges old and older) all disagree with it.
   task automatic model_edge();
      logic inc;
      logic all_diff;
      inc     = m_clean & ~m_clean_d & en;
      m_carry = 1'b0;
      if (inc) begin
         if (m_digit == 4'(MAXC)) begin
            m_digit = 4'd0;
            m_carry = 1'b1;
         end else begin
            m_digit = m_digit + 4'd1;
         end
      end
      hist.push_front(btn);
      all_diff = 1'b1;
      for (int k = 2; k <= DB + 1; k++)
         if (hist[k] == m_clean) all_diff = 1'b0;
      m_clean_d = m_clean;
      if (all_diff) m_clean = hist[2];
      while (hist.size() > DB + 2) void'(hist.pop_back());
   endtask

   task automatic check_all();
      check("digit", {3'b000, digit}, {3'b000, m_digit});
      check("leds", leds, glyph[m_digit]);
      check("carry", {6'd0, carry}, {6'd0, m_carry});
   endtask

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
      model_edge();
      check_all();
      if (carry) carry_seen++;
   endtask

   task automatic press(input logic en_val);
      en  = en_val;
      btn = 1'b1;
      repeat (8) cycle();
      btn = 1'b0;
      repeat (8) cycle();
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      model_reset();
      check("rst_digit", {3'b000, digit}, 7'd0);
      check("rst_leds", leds, 7'b1000000);
      check("rst_carry", {6'd0, carry}, 7'd0);
      repeat (2) begin
         @(negedge clk);
         check_all();
      end
      reset = 1'b1;
   endtask

   initial begin
      logic [3:0] start_digit;
      int         guard;
      glyph = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
      carry_seen = 0;

      // Power-on reset, then idle.
      @(negedge clk);
      do_reset();
      en = 1'b1;
      repeat (20) cycle();
      check("idle_carry_count", 7'(carry_seen), 7'd0);

      // Clean press: digit becomes 1 exactly 6 edges after first high sample.
      btn = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         cycle();
         check("latency", {3'b000, digit}, (i <= 6) ? 7'd0 : 7'd1);
      end
      check("press1_leds", leds, 7'b1111001);
      btn = 1'b0;
      repeat (8) cycle();

      // Bounce filtered, then one increment after a stable hold.
      for (int i = 0; i < 8; i++) begin
         btn = ~i[0];
         cycle();
         check("bounce_hold", {3'b000, digit}, 7'd1);
      end
      btn = 1'b1;
      repeat (10) cycle();
      check("after_bounce", {3'b000, digit}, 7'd2);
      btn = 1'b0;
      repeat (8) cycle();

      // Ten presses wrap exactly once and return to the same digit.
      start_digit = digit;
      carry_seen  = 0;
      for (int p = 0; p < 10; p++) press(1'b1);
      check("ten_press_carries", 7'(carry_seen), 7'd1);
      check("ten_press_digit", {3'b000, digit}, {3'b000, start_digit});

      // Disabled press is discarded; the next enabled press counts.
      start_digit = digit;
      press(1'b0);
      check("en0_press", {3'b000, digit}, {3'b000, start_digit});
      press(1'b1);
      check("en1_press", {3'b000, digit}, {3'b000, start_digit + 4'd1});

      // Reach 5, reset mid-debounce with the button held.
      guard = 0;
      while (m_digit != 4'd5 && guard < 12) begin
         press(1'b1);
         guard++;
      end
      check("reach_five", {3'b000, digit}, 7'd5);
      btn = 1'b1;
      repeat (4) cycle();
      do_reset();
      for (int i = 1; i <= 8; i++) begin
         cycle();
         check("held_through_reset", {3'b000, digit}, (i <= 6) ? 7'd0 : 7'd1);
      end
      btn = 1'b0;
      repeat (8) cycle();

      // Random bouncing, enable toggling and occasional resets.
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(5, 0) == 0) btn = ~btn;
         en = ($urandom_range(7, 0) != 0);
         if ($urandom_range(599, 0) == 0) begin
            do_reset();
         end else begin
            cycle();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
